gpio_in_filter: RTL and testbench

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

---
 rtl/gpio_in_filter.sv | 141 ++++++++++++++
 tb/tb_gpio_in_filter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
// Debounced GPIO input filter: 2-flop sync, tick-sampled 3-of-3 majority filter,
// per-channel rise/fall edge pending bits with interrupt, and a 4-register bus.
module gpio_in_filter #(
   parameter int CH    = 8,
   parameter int PRD_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs_,
   input  logic             as_,
   input  logic             rw,
   input  logic [1:0]       addr,
   input  logic [31:0]      wr_data,
   output logic [31:0]      rd_data,
   output logic             rdy_,
   input  logic [CH-1:0]    pin_in,
   output logic [CH-1:0]    gpio_in,
   output logic             irq
);

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_PERIOD = 2'd1;
   localparam logic [1:0] A_EDGE   = 2'd2;
   localparam logic [1:0] A_PEND   = 2'd3;

   logic [CH-1:0]    meta;
   logic [CH-1:0]    sync;
   logic [CH-1:0]    hist0;
   logic [CH-1:0]    hist1;
   logic [CH-1:0]    rise_en;
   logic [CH-1:0]    fall_en;
   logic [CH-1:0]    pend;
   logic [CH-1:0]    gpio_nxt;
   logic [CH-1:0]    pend_set;
   logic [CH-1:0]    pend_clr;
   logic [PRD_W-1:0] period;
   logic [PRD_W-1:0] cnt;
   logic [31:0]      rd_sel;
   logic             tick;
   logic             access;
   logic             wr;
   logic             unused_wr_bits;

   assign access         = !cs_ && !as_;
   assign wr             = access && !rw;
   assign tick           = (cnt == period);
   assign unused_wr_bits = ^wr_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= pin_in;
         sync <= meta;
      end
   end

   // A PERIOD write restarts the prescaler so the new period starts cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (wr && addr == A_PERIOD) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PRD_W'(1);
      end
   end

   // Output only moves when sync and both history samples agree.
   always_comb begin
      gpio_nxt = gpio_in;
      if (tick) begin
         gpio_nxt = (sync & hist0 & hist1) | (gpio_in & (sync | hist0 | hist1));
      end
      pend_set = (gpio_nxt & ~gpio_in & rise_en) | (~gpio_nxt & gpio_in & fall_en);
      pend_clr = '0;
      if (wr && addr == A_PEND) begin
         pend_clr = wr_data[CH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist0   <= '0;
         hist1   <= '0;
         gpio_in <= '0;
      end else if (tick) begin
         hist0   <= sync;
         hist1   <= hist0;
         gpio_in <= gpio_nxt;
      end
   end

   // A new edge outranks a same-cycle write-1-to-clear on that bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period  <= '0;
         rise_en <= '0;
         fall_en <= '0;
         pend    <= '0;
         irq     <= 1'b0;
      end else begin
         if (wr && addr == A_PERIOD) begin
            period <= wr_data[PRD_W-1:0];
         end
         if (wr && addr == A_EDGE) begin
            rise_en <= wr_data[CH-1:0];
            fall_en <= wr_data[16+CH-1:16];
         end
         pend <= (pend & ~pend_clr) | pend_set;
         irq  <= |pend;
      end
   end

   always_comb begin
      rd_sel = '0;
      case (addr)
         A_DATA:   rd_sel[CH-1:0] = gpio_in;
         A_PERIOD: rd_sel[PRD_W-1:0] = period;
         A_EDGE: begin
            rd_sel[CH-1:0]      = rise_en;
            rd_sel[16+CH-1:16]  = fall_en;
         end
         default:  rd_sel[CH-1:0] = pend;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_    <= 1'b1;
         rd_data <= '0;
      end else begin
         rdy_    <= !access;
         rd_data <= (access && rw) ? rd_sel : '0;
      end
   end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios plus random pin/bus traffic,
// scored against a reference model built from per-tick sample lists.
module tb_gpio_in_filter;
   localparam int CH    = 8;
   localparam int PRD_W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cs_;
   logic          as_;
   logic          rw;
   logic [1:0]    addr;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic          rdy_;
   logic [CH-1:0] pin_in;
   logic [CH-1:0] gpio_in;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_in_filter #(.CH(CH), .PRD_W(PRD_W)) dut (
      .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .pin_in(pin_in),
      .gpio_in(gpio_in), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [CH-1:0]    m_gpio, m_rise, m_fall, m_pend;
   logic [PRD_W-1:0] m_period;
   logic             m_irq;
   int unsigned      m_edge, m_wedge;
   logic [CH-1:0]    m_pins[$];
   logic [CH-1:0]    m_smp[$];
   logic [31:0]      exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: r[CH-1:0] = m_gpio;
         2'd1: r[PRD_W-1:0] = m_period;
         2'd2: begin
            r[CH-1:0]     = m_rise;
            r[16+CH-1:16] = m_fall;
         end
         default: r[CH-1:0] = m_pend;
      endcase
      return r;
   endfunction

   // The pin seen by the filter at edge e is the pin captured at edge e-2;
   // ticks fall every PERIOD+1 edges counted from the last PERIOD write (or reset).
   always @(posedge clk or negedge reset) begin : model
      logic          acc, wr, tick;
      logic [CH-1:0] s, ng, a0, a1, a2, setm, clr;
      int unsigned   prd1;
      if (!reset) begin
         m_gpio = '0; m_rise = '0; m_fall = '0; m_pend = '0;
         m_period = '0; m_irq = 1'b0;
         m_edge = 0; m_wedge = 0;
         m_pins = '{CH'(0), CH'(0)};
         m_smp  = '{CH'(0), CH'(0)};
         exp_q.delete();
      end else begin
         acc = !cs_ && !as_;
         wr  = acc && !rw;
         m_edge++;
         prd1 = 32'(m_period) + 32'd1;
         tick = ((m_edge - m_wedge) % prd1) == 0;
         s = m_pins[0];
         m_pins.push_back(pin_in);
         m_pins.delete(0);
         ng = m_gpio;
         if (tick) begin
            m_smp.push_back(s);
            if (m_smp.size() > 3) m_smp.delete(0);
            a0 = m_smp[0]; a1 = m_smp[1]; a2 = m_smp[2];
            for (int i = 0; i < CH; i++)
               if (a0[i] == a1[i] && a1[i] == a2[i]) ng[i] = a2[i];
         end
         setm = (ng & ~m_gpio & m_rise) | (~ng & m_gpio & m_fall);
         clr  = (wr && addr == 2'd3) ? wr_data[CH-1:0] : '0;
         m_irq  = |m_pend;
         m_pend = (m_pend & ~clr) | setm;
         m_gpio = ng;
         if (wr && addr == 2'd1) begin
            m_period = wr_data[PRD_W-1:0];
            m_wedge  = m_edge;
         end
         if (wr && addr == 2'd2) begin
            m_rise = wr_data[CH-1:0];
            m_fall = wr_data[16+CH-1:16];
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [31:0] e;
      if (reset) begin
         chk("gpio_in", 32'(gpio_in), 32'(m_gpio));
         chk("irq", 32'(irq), 32'(m_irq));
         if (!rdy_) begin
            if (exp_q.size() == 0) begin
               chk("rdy_ without access", 32'(rdy_), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", rd_data, e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_op(input logic r, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
      exp_q.push_back(r ? model_read(a) : 32'h0);
      @(negedge clk);
      chk("rdy_ after strobe", 32'(rdy_), 32'd0);
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b1;
   endtask

   task automatic rand_bus();
      logic        r;
      logic [1:0]  a;
      logic [31:0] d;
      r = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 3);
      bus_op(r, a, d);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not end, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0; pin_in = '0;
      #1 reset = 1'b0;
      idle(3);
      chk("reset rd_data", rd_data, 32'h0);
      chk("reset rdy_", 32'(rdy_), 32'd1);
      chk("reset gpio_in", 32'(gpio_in), 32'h0);
      chk("reset irq", 32'(irq), 32'h0);
      reset = 1'b1;
      idle(2);

      // Latency with PERIOD=0
      @(negedge clk); pin_in[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("gpio_in[0] after N+3", 32'(gpio_in[0]), 32'd0);
      @(posedge clk);
      #1 chk("gpio_in[0] after N+4", 32'(gpio_in[0]), 32'd1);
      bus_op(1'b1, 2'd0, 32'h0);

      // PERIOD full-width readback, empty PEND
      bus_op(1'b0, 2'd1, 32'hFFFF_FFFF);
      bus_op(1'b1, 2'd1, 32'h0);
      bus_op(1'b1, 2'd3, 32'h0);
      bus_op(1'b1, 2'd2, 32'h0);

      // Two-tick glitch with PERIOD=3
      bus_op(1'b0, 2'd1, 32'd3);
      bus_op(1'b0, 2'd2, 32'h0000_0002);
      @(negedge clk); pin_in[1] = 1'b1;
      idle(8);
      pin_in[1] = 1'b0;
      idle(20);
      chk("glitch gpio_in[1]", 32'(gpio_in[1]), 32'd0);
      chk("glitch irq", 32'(irq), 32'd0);
      bus_op(1'b1, 2'd3, 32'h0);

      // Rise, clear, fall
      bus_op(1'b0, 2'd1, 32'd0);
      @(negedge clk); pin_in[0] = 1'b0;
      idle(20);
      bus_op(1'b0, 2'd3, 32'hFFFF_FFFF);
      bus_op(1'b0, 2'd2, 32'h0001_0001);
      @(negedge clk); pin_in[0] = 1'b1;
      idle(20);
      chk("irq after rise", 32'(irq), 32'd1);
      bus_op(1'b1, 2'd3, 32'h0);
      bus_op(1'b0, 2'd3, 32'h1);
      @(posedge clk);
      #1 chk("irq after clear", 32'(irq), 32'd0);
      @(negedge clk); pin_in[0] = 1'b0;
      idle(20);
      chk("irq after fall", 32'(irq), 32'd1);
      bus_op(1'b1, 2'd3, 32'h0);

      // W1C colliding with a new rise on channel 2
      bus_op(1'b0, 2'd2, 32'h0000_0004);
      @(negedge clk); pin_in[2] = 1'b1;
      idle(3);
      bus_op(1'b0, 2'd3, 32'h5);
      bus_op(1'b1, 2'd3, 32'h0);
      chk("irq after set-wins", 32'(irq), 32'd1);

      // Fill PEND, start a debounce, then pulse reset between edges
      bus_op(1'b0, 2'd2, 32'h00FF_00FF);
      @(negedge clk); pin_in = '0;
      idle(10);
      @(negedge clk); pin_in = '1;
      idle(10);
      bus_op(1'b1, 2'd3, 32'h0);
      @(negedge clk); pin_in = '0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async reset rd_data", rd_data, 32'h0);
      chk("async reset rdy_", 32'(rdy_), 32'd1);
      chk("async reset gpio_in", 32'(gpio_in), 32'h0);
      chk("async reset irq", 32'(irq), 32'h0);
      @(posedge clk);
      @(negedge clk); reset = 1'b1;
      bus_op(1'b1, 2'd1, 32'h0);
      bus_op(1'b1, 2'd2, 32'h0);
      bus_op(1'b1, 2'd3, 32'h0);
      @(negedge clk); pin_in = 8'hA5;
      idle(10);
      chk("gpio_in after reset", 32'(gpio_in), 32'h0000_00A5);
      chk("irq after reset", 32'(irq), 32'h0);
      bus_op(1'b1, 2'd3, 32'h0);
      bus_op(1'b1, 2'd0, 32'h0);

      // Random traffic
      for (int k = 0; k < 2500; k++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r < 2) begin
            @(negedge clk); pin_in[$urandom_range(0, CH-1)] ^= 1'b1;
         end else if (r < 3) begin
            @(negedge clk); pin_in = pin_in ^ CH'($urandom);
         end else if (r < 6) begin
            rand_bus();
         end else begin
            @(negedge clk);
         end
      end

      idle(10);
      chk("outstanding responses", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
